stream_decoder_core: RTL and testbench
======================================

# stream_decoder_core

Per-channel phase decoder that sits directly downstream of the binary-to-stream encoder. It consumes NI+NO one-bit pulse streams, one bit per channel per accepted beat. Over each window of 2^WR beats it recovers the signed WR-bit value whose encoding is a half-period square wave with phase v. It emits one NI+NO-word binary vector per window through a valid/ready handshake, so an encoder → reservoir → decoder chain closes the loop back to binary.

## Interface
- NI, default 1: number of input channels (shared design parameter).
- NO, default 1: number of output channels (shared design parameter); N = NI+NO lanes decoded.
- WR, default 8: word width; window length 2^WR beats; H = 2^(WR-1).
- iCLK  in  1: single clock, all state on rising edge.
- iRST  in  1: reset, synchronous, active-high.
- iValid_AS  in  1: stream beat valid.
- oReady_AS  out  1: decoder accepts beat.
- iData_AS  in  N: one stream bit per channel; bit k = channel k.
- oValid_BS  out  1: decoded vector valid.
- iReady_BS  in  1: downstream accepts vector.
- oData_BS  out  N*WR: two's-complement words; channel k at [k*WR +: WR].

## Operation
- Beat = cycle with iValid_AS && oReady_AS. Only beats advance state.
- Phase counter rcnt, WR-bit signed: starts at -H (MINUS_ONE = {1,0..0}) and increments per beat. A window ends on the beat with rcnt == H-1 (PLUS_ONE), then wraps to -H.
- Encoding being inverted: for value v, the stream is 1 exactly when rcnt ∈ [v-H, v), modulo 2^WR. Decoded value = rcnt index of the circular falling edge: stream bit at index i-1 is 1 and bit at index i is 0.
- Per channel registers:
  - first: bit at index -H.
  - prev: last accepted bit.
  - cap: WR-bit captured edge index.
  - hit: edge-found flag.
- On each beat with index > -H: if prev==1 && bit==0 then cap<=rcnt, hit<=1. A later edge overwrites an earlier one (highest in-window index wins).
- On the last beat, wrap check: if bit==1 && first==0 and no in-window edge (including this beat), the result is -H. Wrap edge has lowest priority.
- No edge at all (constant stream): result 0.
- Result vector loaded into output register on last beat; cap/hit cleared for the next window.
- States: IDLE (one cycle after reset, oReady_AS=0, oValid_BS=0) → RUN (unconditional). Any state with iRST → IDLE.
- Overlap: the next window streams in while the previous result waits.
- oReady_AS = (state==RUN) && !(rcnt==PLUS_ONE && oValid_BS && !iReady_BS). It stalls only the final beat that would overwrite an unaccepted result.
- oValid_BS set on last-beat load; cleared when iReady_BS && !load. Load and accept in the same cycle: new vector replaces the old one, valid stays 1.

## Timing
- Reset values: oValid_BS=0, oReady_AS=0, oData_BS=0, rcnt=-H, first/prev/hit=0, cap=0.
- Latency: oValid_BS rises the cycle after the last beat of a window is accepted. Throughput is one vector per 2^WR beats with no bubble.
- oData_BS is stable while oValid_BS && !iReady_BS.
- oReady_AS is combinational from iReady_BS only on the last-beat stall condition; no combinational iValid_AS → oValid_BS path.
- iValid_AS low mid-window: rcnt and all channel registers hold; the window resumes.
- Reset mid-window: partial window discarded; next window starts at rcnt=-H after the IDLE cycle. A pending output is dropped.

## Test plan
- Clean encoder streams, WR=8, v=0 (1 on rcnt -128..-1) → 0; v=5 (1 on -123..4) → 5, one vector per 256 beats.
- Boundaries: v=127 (1 on -1..126) → 127; v=-128 (1 on 0..127, wrap edge) → -128 (0x80); v=-1 → 0xFF.
- Constant 0 and constant 1 streams → 0 on all channels; two channels with different v in the same window decode independently.
- Random iValid_AS gaps (30% idle) over 8 windows of random v → exact values, in order, none lost.
- iReady_BS held low across a whole next window: oReady_AS drops only at the rcnt==127 beat; first vector stable. Release iReady_BS → first accepted, second follows the next cycle.
- iRST asserted at beat 100 → outputs reset, oReady_AS low one cycle. The next full window decodes correctly, with no stale vector emitted.

Source files
------------

// File: rtl/stream_decoder_core.sv
// stream_decoder_core: recovers one signed WR-bit value per channel from a
// half-period square-wave pulse stream, one vector per 2^WR accepted beats.
// The decoded value is the window index of the circular falling edge.
//
// Handshakes: a transfer on either side happens on a rising clock edge where
// valid and ready are both high; valid, once raised, holds with stable data
// until that transfer; ready may depend combinationally on the consumer's
// ready only on the final-beat stall condition.
module stream_decoder_core #(
    parameter int NI = 1,
    parameter int NO = 1,
    parameter int WR = 8
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iValid_AS,
    output logic               oReady_AS,
    input  logic [NI+NO-1:0]   iData_AS,
    output logic               oValid_BS,
    input  logic               iReady_BS,
    output logic [(NI+NO)*WR-1:0] oData_BS
);

    localparam int N = NI + NO;
    localparam logic [WR-1:0] MINUS_ONE = {1'b1, {(WR-1){1'b0}}};
    localparam logic [WR-1:0] PLUS_ONE  = {1'b0, {(WR-1){1'b1}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    state_t                state_next;
    logic [WR-1:0]         rcnt;
    logic [N-1:0]          first;
    logic [N-1:0]          prev;
    logic [N-1:0]          hit;
    logic [N-1:0][WR-1:0]  cap;
    logic [N*WR-1:0]       result;
    logic [N*WR-1:0]       data_q;
    logic                  valid_q;
    logic                  beat;
    logic                  last;
    logic                  at_start;
    logic                  load;

    assign last      = (rcnt == PLUS_ONE);
    assign at_start  = (rcnt == MINUS_ONE);
    // Only the final beat stalls, and only if it would overwrite a result
    // the consumer has not yet taken.
    assign oReady_AS = (state == RUN) && !(last && valid_q && !iReady_BS);
    assign beat      = iValid_AS && oReady_AS;
    assign load      = beat && last;
    assign oValid_BS = valid_q;
    assign oData_BS  = data_q;

    // State register: IDLE for exactly one cycle after reset.
    always_ff @(posedge iCLK) begin
        if (iRST) state <= IDLE;
        else      state <= state_next;
    end

    // Next state: IDLE always moves to RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Final-beat result: this beat's edge, then latest in-window edge,
    // then the wrap edge at -H, otherwise 0 for a constant stream.
    always_comb begin
        result = '0;
        for (int k = 0; k < N; k++) begin
            if (prev[k] && !iData_AS[k])
                result[k*WR +: WR] = rcnt;
            else if (hit[k])
                result[k*WR +: WR] = cap[k];
            else if (iData_AS[k] && !first[k])
                result[k*WR +: WR] = MINUS_ONE;
            else
                result[k*WR +: WR] = '0;
        end
    end

    // Phase counter and per-channel edge tracking; advances on beats only.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rcnt  <= MINUS_ONE;
            first <= '0;
            prev  <= '0;
            hit   <= '0;
            cap   <= '0;
        end else if (beat) begin
            rcnt <= rcnt + 1'b1;
            for (int k = 0; k < N; k++) begin
                prev[k] <= iData_AS[k];
                if (at_start) begin
                    first[k] <= iData_AS[k];
                end else if (last) begin
                    hit[k] <= 1'b0;
                    cap[k] <= '0;
                end else if (prev[k] && !iData_AS[k]) begin
                    hit[k] <= 1'b1;
                    cap[k] <= rcnt;
                end
            end
        end
    end

    // Output register: load on the final beat, drop valid once accepted.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= result;
        end else if (iReady_BS) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_decoder_core.sv
// Directed bench for stream_decoder_core (WR=8, two channels).
module tb_stream_decoder_core;

    localparam int WR = 8;
    localparam int N  = 2;

    logic            clk;
    logic            iRST;
    logic            iValid_AS;
    logic            oReady_AS;
    logic [N-1:0]    iData_AS;
    logic            oValid_BS;
    logic            iReady_BS;
    logic [N*WR-1:0] oData_BS;

    logic [N*WR-1:0] exp_q[$];
    int              hs_cyc[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              beat_idx = 0;

    stream_decoder_core #(.NI(1), .NO(1), .WR(WR)) dut (
        .iCLK      (clk),
        .iRST      (iRST),
        .iValid_AS (iValid_AS),
        .oReady_AS (oReady_AS),
        .iData_AS  (iData_AS),
        .oValid_BS (oValid_BS),
        .iReady_BS (iReady_BS),
        .oData_BS  (oData_BS)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Encoder model: stream is 1 when index r lies in [v-128, v) mod 256.
    // mode 0 = encoder, 1 = constant 0, 2 = constant 1.
    function automatic logic enc_bit(input int v, input int r, input int mode);
        int d;
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        d = (((r - v) % 256) + 256) % 256;
        return (d >= 128);
    endfunction

    function automatic logic [7:0] exp_val(input int v, input int mode);
        logic [31:0] t;
        if (mode != 0) return 8'h00;
        t = v;
        return t[7:0];
    endfunction

    // Scoreboard: every output handshake pops one expected vector.
    always @(negedge clk) begin
        cyc++;
        if (!iRST && oValid_BS && iReady_BS) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) check_eq("spurious_vec", 32'd1, 32'd0);
            else check_eq("vec", {16'h0, oData_BS}, {16'h0, exp_q.pop_front()});
        end
    end

    task automatic drive_beat(input logic [N-1:0] bits);
        int waited;
        waited = 0;
        iValid_AS = 1'b1;
        iData_AS  = bits;
        forever begin
            @(negedge clk);
            if (oReady_AS) begin
                @(posedge clk); #1;
                break;
            end
            waited++;
            if (waited > 2000) begin
                check_eq("ready_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        iValid_AS = 1'b0;
    endtask

    task automatic send_window(input int v0, input int m0, input int v1, input int m1,
                               input int gap_pct, input int nbeats);
        if (nbeats == 256) exp_q.push_back({exp_val(v1, m1), exp_val(v0, m0)});
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                iValid_AS = 1'b0;
                @(posedge clk); #1;
            end
            beat_idx = b;
            drive_beat({enc_bit(v1, b - 128, m1), enc_bit(v0, b - 128, m0)});
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 600) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset
        iRST = 1'b1; iValid_AS = 1'b0; iData_AS = '0; iReady_BS = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_valid", oValid_BS, 0);
        check_eq("rst_ready", oReady_AS, 0);
        check_eq("rst_data",  oData_BS, 0);
        @(posedge clk); #1;
        iRST = 1'b0;

        // Directed windows
        send_window(0, 0, 5, 0, 0, 256);
        @(negedge clk);
        check_eq("latency_valid", oValid_BS, 1);
        @(posedge clk); #1;
        send_window(127, 0, -128, 0, 0, 256);
        send_window(-1, 0, 0, 1, 0, 256);
        send_window(0, 2, -5, 0, 0, 256);
        send_window(1, 0, -127, 0, 0, 256);
        drain();

        // Random values with idle gaps
        for (int w = 0; w < 8; w++)
            send_window(int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 255)), 0, 30, 256);
        drain();

        // Backpressure across a whole window
        iReady_BS = 1'b0;
        send_window(10, 0, 20, 0, 0, 256);
        fork
            send_window(30, 0, -40, 0, 0, 256);
            begin
                int w;
                logic [N*WR-1:0] held;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!(iValid_AS && !oReady_AS) && w < 1000);
                check_eq("stall_beat", beat_idx, 255);
                check_eq("stall_valid", oValid_BS, 1);
                held = exp_q[0];
                check_eq("stall_data", {16'h0, oData_BS}, {16'h0, held});
                repeat (3) @(negedge clk);
                check_eq("stall_hold_ready", oReady_AS, 0);
                check_eq("stall_hold_data", {16'h0, oData_BS}, {16'h0, held});
                @(posedge clk); #1;
                iReady_BS = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check_eq("b2b_gap", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], 1);
        drain();

        // Reset mid-window with a pending vector
        iReady_BS = 1'b0;
        send_window(50, 0, 60, 0, 0, 256);
        @(negedge clk);
        check_eq("pend_valid", oValid_BS, 1);
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        send_window(70, 0, 80, 0, 0, 100);
        iRST = 1'b1;
        @(posedge clk); #1;
        iRST = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", oValid_BS, 0);
        check_eq("mid_rst_ready", oReady_AS, 0);
        check_eq("mid_rst_data",  oData_BS, 0);
        @(negedge clk);
        check_eq("mid_rst_run", oReady_AS, 1);
        @(posedge clk); #1;
        iReady_BS = 1'b1;
        send_window(-100, 0, 100, 0, 0, 256);
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
